add_sub: RTL and testbench

ADD_SUB -- requirements
Module: add_sub

---
 rtl/add_sub.sv | 63 ++++++
 tb/tb_add_sub.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/add_sub.sv
// Registered signed add/subtract with carry/borrow flag and one-cycle latency.
// Optional saturated output ANS_SAT is enabled by defining ADD_SUB_SAT_EN.
module add_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    SUB,
  input  logic                    IN_VLD,
  output logic signed [WIDTH:0]   ANS,
  output logic                    CY_BR_OUT,
  output logic                    OUT_VLD
`ifdef ADD_SUB_SAT_EN
  ,
  output logic signed [WIDTH-1:0] ANS_SAT
`endif
);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_op;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Subtract reuses the adder: invert B and inject SUB as the carry-in.
  always_comb begin
    a_ext = {A[WIDTH-1], A};
    b_op  = {B[WIDTH-1], B} ^ {(WIDTH+1){SUB}};
    sum   = a_ext + b_op + {{WIDTH{1'b0}}, SUB};
    ovf   = sum[WIDTH] ^ sum[WIDTH-1];
  end

`ifdef ADD_SUB_SAT_EN
  logic [WIDTH-1:0] sat;

  // Clamp towards the sign of the exact result.
  always_comb begin
    sat = sum[WIDTH-1:0];
    if (ovf) sat = {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      ANS_SAT <= '0;
    else if (IN_VLD) ANS_SAT <= sat;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ANS       <= '0;
      CY_BR_OUT <= 1'b0;
      OUT_VLD   <= 1'b0;
    end else begin
      OUT_VLD <= IN_VLD;
      if (IN_VLD) begin
        ANS       <= sum;
        CY_BR_OUT <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard bench for add_sub: directed, exhaustive, random, hold and async-reset checks.
module tb_add_sub;
  localparam int W    = 4;
  localparam int RMIN = -(1 << (W-1));
  localparam int RMAX = (1 << (W-1)) - 1;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic signed [W-1:0] A = '0;
  logic signed [W-1:0] B = '0;
  logic                SUB = 1'b0;
  logic                IN_VLD = 1'b0;
  logic signed [W:0]   ANS;
  logic                CY_BR_OUT;
  logic                OUT_VLD;
`ifdef ADD_SUB_SAT_EN
  logic signed [W-1:0] ANS_SAT;
`endif

  add_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .SUB(SUB), .IN_VLD(IN_VLD),
    .ANS(ANS), .CY_BR_OUT(CY_BR_OUT), .OUT_VLD(OUT_VLD)
`ifdef ADD_SUB_SAT_EN
    , .ANS_SAT(ANS_SAT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {int ans; int cy; int sat;} exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_ans = 0;
  int last_cy  = 0;
  int last_sat = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge; expectation
  // comes from plain integer arithmetic, not from the adder structure.
  task automatic drive(input int a, input int b, input int sub, input bit vld, input bit push);
    exp_t e;
    int r;
    @(posedge CLK);
    #1;
    A = a[W-1:0]; B = b[W-1:0]; SUB = sub[0]; IN_VLD = vld;
    if (vld && push) begin
      r     = (sub != 0) ? a - b : a + b;
      e.ans = r;
      e.cy  = (r < RMIN || r > RMAX) ? 1 : 0;
      e.sat = (r < RMIN) ? RMIN : (r > RMAX) ? RMAX : r;
      q.push_back(e);
    end
  endtask

  // Monitor: pop on every valid output, otherwise outputs must hold.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      last_ans = 0; last_cy = 0; last_sat = 0;
    end else if (OUT_VLD) begin
      if (q.size() == 0) begin
        check("unexpected_out_vld", 1, 0);
      end else begin
        e = q.pop_front();
        check("ans", int'(ANS), e.ans);
        check("cy_br_out", int'(CY_BR_OUT), e.cy);
`ifdef ADD_SUB_SAT_EN
        check("ans_sat", int'(ANS_SAT), e.sat);
`endif
        last_ans = e.ans; last_cy = e.cy; last_sat = e.sat;
      end
    end else begin
      check("hold_ans", int'(ANS), last_ans);
      check("hold_cy", int'(CY_BR_OUT), last_cy);
`ifdef ADD_SUB_SAT_EN
      check("hold_sat", int'(ANS_SAT), last_sat);
`endif
    end
  end

  initial begin
    #12;
    check("rst_ans", int'(ANS), 0);
    check("rst_cy", int'(CY_BR_OUT), 0);
    check("rst_vld", int'(OUT_VLD), 0);
    #11 RST_N = 1'b1;

    // Boundary cases
    drive( 7,  1, 0, 1'b1, 1'b1);
    drive(-8,  1, 1, 1'b1, 1'b1);
    drive(-8, -8, 0, 1'b1, 1'b1);
    drive( 7, -8, 1, 1'b1, 1'b1);
    drive(-8, -8, 1, 1'b1, 1'b1);
    drive( 0,  0, 0, 1'b0, 1'b0);

    // Exhaustive sweep, back-to-back
    for (int s = 0; s < 2; s++)
      for (int b = RMIN; b <= RMAX; b++)
        for (int a = RMIN; a <= RMAX; a++)
          drive(a, b, s, 1'b1, 1'b1);

    // Hold: operands change while IN_VLD is low
    for (int i = 0; i < 8; i++)
      drive($urandom_range(15) - 8, $urandom_range(15) - 8, $urandom_range(1), 1'b0, 1'b0);

    // Random traffic with gaps
    for (int i = 0; i < 300; i++)
      drive($urandom_range(15) - 8, $urandom_range(15) - 8, $urandom_range(1),
            ($urandom_range(3) != 0), 1'b1);

    // Async reset mid-stream: the op in flight when reset falls is discarded
    drive(3, 2, 0, 1'b1, 1'b1);
    drive(-5, 6, 1, 1'b1, 1'b0);
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_ans", int'(ANS), 0);
    check("async_rst_cy", int'(CY_BR_OUT), 0);
    check("async_rst_vld", int'(OUT_VLD), 0);
    A = 4'sd7; B = 4'sd1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold_ans", int'(ANS), 0);
    check("rst_hold_vld", int'(OUT_VLD), 0);
    IN_VLD = 1'b0;
    #2 RST_N = 1'b1;
    drive( 7,  1, 0, 1'b1, 1'b1);
    drive(-6, -3, 0, 1'b1, 1'b1);
    drive(-8,  7, 1, 1'b1, 1'b1);

    repeat (3) drive(0, 0, 0, 1'b0, 1'b0);
    @(posedge CLK);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
